// File: rtl/slice_cfg_pkg.sv
// rtl/slice_cfg_pkg.sv - shared constants and FSM state type for the slice config loader
package slice_cfg_pkg;

  localparam int SLICE_CHAIN_LEN = 144;
  localparam int CFG_WORD_W      = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT,
    DONE
  } cfg_state_e;

endpackage

// File: rtl/cfg_piso.sv
// rtl/cfg_piso.sv - parallel-in/serial-out word register with a bits-left count
module cfg_piso #(
  parameter int WORD_W = 32,
  parameter int BL_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  input  logic [BL_W-1:0]   load_bits,
  output logic              sbit,
  output logic [BL_W-1:0]   bits_left
);

  logic [WORD_W-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      bits_left <= '0;
    end else if (load) begin
      sreg      <= load_data;
      bits_left <= load_bits;
    end else if (shift && (bits_left != '0)) begin
      sreg      <= sreg >> 1;
      bits_left <= bits_left - BL_W'(1);
    end
  end

  assign sbit = sreg[0];

endmodule

// File: rtl/slice_cfg_loader.sv
// rtl/slice_cfg_loader.sv - streams bitstream words LSB-first into one slice config chain
module slice_cfg_loader
  import slice_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = SLICE_CHAIN_LEN,
  parameter int WORD_W    = CFG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_cen,
  output logic              cfg_shift,
  output logic              cfg_set,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BL_W  = $clog2(WORD_W + 1);

  cfg_state_e       state, state_next;
  logic [CNT_W-1:0] bitcnt, bitcnt_next;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      remaining_wide;
  logic [BL_W-1:0]  load_bits;
  logic [BL_W-1:0]  bits_left;
  logic             sbit;
  logic             piso_load;
  logic             piso_shift;

  // The final word only contributes the bits still missing from the chain.
  assign remaining      = CNT_W'(CHAIN_LEN) - bitcnt;
  assign remaining_wide = 32'(remaining);
  assign load_bits      = (remaining_wide >= 32'(WORD_W)) ? BL_W'(WORD_W) : BL_W'(remaining_wide);

  cfg_piso #(
    .WORD_W (WORD_W),
    .BL_W   (BL_W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (piso_load),
    .shift     (piso_shift),
    .load_data (in_data),
    .load_bits (load_bits),
    .sbit      (sbit),
    .bits_left (bits_left)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
    end else begin
      state  <= state_next;
      bitcnt <= bitcnt_next;
    end
  end

  // Outputs decode only registered state and the PISO LSB, so they move on clock edges.
  always_comb begin
    state_next  = state;
    bitcnt_next = bitcnt;
    in_ready    = 1'b0;
    cfg_cen     = 1'b0;
    cfg_shift   = 1'b0;
    cfg_set     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = LOAD;
          bitcnt_next = '0;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          piso_load  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy        = 1'b1;
        cfg_cen     = 1'b1;
        cfg_shift   = sbit;
        piso_shift  = 1'b1;
        bitcnt_next = bitcnt + CNT_W'(1);
        if (bitcnt_next == CNT_W'(CHAIN_LEN)) begin
          state_next = COMMIT;
        end else if (bits_left == BL_W'(1)) begin
          state_next = LOAD;
        end
      end
      COMMIT: begin
        busy       = 1'b1;
        cfg_set    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done        = 1'b1;
        bitcnt_next = '0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_slice_cfg_loader.sv
// tb/tb_slice_cfg_loader.sv - directed table-driven bench for slice_cfg_loader
module tb_slice_cfg_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cfg_cen;
  logic        cfg_shift;
  logic        cfg_set;
  logic        busy;
  logic        done;

  slice_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_cen   (cfg_cen),
    .cfg_shift (cfg_shift),
    .cfg_set   (cfg_set),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w [5];
    int          gap;
    bit          start_mid;
    int          set_cyc;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] cur_words [5];
  int          n_total;
  int          n_pass;

  int           cen_cnt, set_cnt, done_cnt, set_cycle, done_cycle, widx, viol;
  logic [143:0] chain, captured;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one load; rst_at > 0 aborts with reset once that many bits have been shifted.
  task automatic run_load(input int gap, input bit start_mid, input int rst_at);
    int  k;
    int  gap_cnt;
    bit  hs_pending;
    bit  mid_sent;
    int  abort_phase;
    bit  finished;
    k = 0; gap_cnt = 0; mid_sent = 0; abort_phase = 0; finished = 0;
    cen_cnt = 0; set_cnt = 0; done_cnt = 0; set_cycle = -1; done_cycle = -1;
    widx = 0; viol = 0; chain = '0; captured = '0;
    @(negedge clk);
    start    = 1'b1;
    in_data  = cur_words[0];
    in_valid = 1'b1;
    hs_pending = in_valid && in_ready;
    while (!finished) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (hs_pending) widx++;
      if (cfg_shift && !cfg_cen) viol++;
      if (cfg_cen) begin
        cen_cnt++;
        chain = {cfg_shift, chain[143:1]};
      end
      if (cfg_set) begin
        set_cnt++;
        set_cycle = k;
        captured  = chain;
      end
      if (done) begin
        done_cnt++;
        done_cycle = k;
      end
      if (k == 1) chk("busy_ready_at_load", {142'd0, busy, in_ready}, 144'd3);
      if (abort_phase == 1) begin
        chk("rst_outputs_zero", {138'd0, in_ready, cfg_cen, cfg_shift, cfg_set, busy, done}, 144'd0);
        rst = 1'b0;
        abort_phase = 2;
      end else if (abort_phase >= 2) begin
        abort_phase++;
        if (abort_phase == 6) begin
          chk("rst_no_set", 144'(set_cnt), 144'd0);
          chk("rst_no_done", 144'(done_cnt), 144'd0);
          finished = 1;
        end
      end else if (rst_at > 0 && cen_cnt == rst_at) begin
        rst = 1'b1;
        abort_phase = 1;
      end
      if (start_mid && !mid_sent && cen_cnt == 50) begin
        start    = 1'b1;
        mid_sent = 1;
      end
      if (widx >= 5) begin
        in_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
      end else begin
        in_data = cur_words[widx];
        if (widx == 2 && in_ready && gap_cnt < gap) begin
          in_valid = 1'b0;
          gap_cnt++;
        end else begin
          in_valid = 1'b1;
        end
      end
      hs_pending = in_valid && in_ready;
      if (rst_at == 0 && done_cnt > 0 && k >= done_cycle + 3) finished = 1;
      if (k >= 800) begin
        chk("timeout", 144'd1, 144'd0);
        finished = 1;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0;

    vecs[0].w[0] = 32'h1234_5678; vecs[0].w[1] = 32'h9ABC_DEF0; vecs[0].w[2] = 32'h0F0F_F0F0;
    vecs[0].w[3] = 32'hA5A5_5A5A; vecs[0].w[4] = 32'h0000_C3E1;
    vecs[0].gap = 0; vecs[0].start_mid = 0; vecs[0].set_cyc = 150;
    vecs[1].w[0] = 32'hFFFF_FFFF; vecs[1].w[1] = 32'h0000_0000; vecs[1].w[2] = 32'h8000_0001;
    vecs[1].w[3] = 32'h7FFF_FFFE; vecs[1].w[4] = 32'hFFFF_0000;
    vecs[1].gap = 0; vecs[1].start_mid = 0; vecs[1].set_cyc = 150;
    vecs[2].w[0] = 32'hCAFE_F00D; vecs[2].w[1] = 32'h1357_9BDF; vecs[2].w[2] = 32'h2468_ACE0;
    vecs[2].w[3] = 32'h0BAD_C0DE; vecs[2].w[4] = 32'h5555_AAAA;
    vecs[2].gap = 7; vecs[2].start_mid = 0; vecs[2].set_cyc = 157;
    vecs[3].w[0] = 32'h8421_1248; vecs[3].w[1] = 32'hF00F_0FF0; vecs[3].w[2] = 32'h3C3C_C3C3;
    vecs[3].w[3] = 32'h6996_9669; vecs[3].w[4] = 32'hFFFF_7E81;
    vecs[3].gap = 0; vecs[3].start_mid = 1; vecs[3].set_cyc = 150;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {138'd0, in_ready, cfg_cen, cfg_shift, cfg_set, busy, done}, 144'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {138'd0, in_ready, cfg_cen, cfg_shift, cfg_set, busy, done}, 144'd0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 5; i++) cur_words[i] = vecs[v].w[i];
      run_load(vecs[v].gap, vecs[v].start_mid, 0);
      chk($sformatf("v%0d_cen_count", v), 144'(cen_cnt), 144'd144);
      chk($sformatf("v%0d_set_count", v), 144'(set_cnt), 144'd1);
      chk($sformatf("v%0d_done_count", v), 144'(done_cnt), 144'd1);
      chk($sformatf("v%0d_set_cycle", v), 144'(set_cycle), 144'(vecs[v].set_cyc));
      chk($sformatf("v%0d_done_cycle", v), 144'(done_cycle), 144'(vecs[v].set_cyc + 1));
      chk($sformatf("v%0d_words_used", v), 144'(widx), 144'd5);
      chk($sformatf("v%0d_shift_gating", v), 144'(viol), 144'd0);
      chk($sformatf("v%0d_chain", v), captured,
          {vecs[v].w[4][15:0], vecs[v].w[3], vecs[v].w[2], vecs[v].w[1], vecs[v].w[0]});
      chk($sformatf("v%0d_idle_after", v), {142'd0, busy, in_ready}, 144'd0);
    end

    cur_words[0] = 32'h0123_4567; cur_words[1] = 32'h89AB_CDEF; cur_words[2] = 32'hFEDC_BA98;
    cur_words[3] = 32'h7654_3210; cur_words[4] = 32'h0000_9D2B;
    run_load(0, 0, 70);
    run_load(0, 0, 0);
    chk("reload_cen_count", 144'(cen_cnt), 144'd144);
    chk("reload_set_count", 144'(set_cnt), 144'd1);
    chk("reload_set_cycle", 144'(set_cycle), 144'd150);
    chk("reload_chain", captured,
        {cur_words[4][15:0], cur_words[3], cur_words[2], cur_words[1], cur_words[0]});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
